// File: rtl/rob_commit_unit_if.sv
// Dispatch, completion and commit signal bundle of the reorder buffer.
// master = core side (dispatch/writeback/flush); slave = rob_commit_unit.
interface rob_commit_unit_if #(
    parameter int IDXW = 5
);
    logic                 flush;
    logic                 disp_valid_0, disp_valid_1;
    logic                 disp_wen_0, disp_wen_1;
    logic [4:0]           disp_arch_0, disp_arch_1;
    logic [5:0]           disp_prf_0, disp_prf_1;
    logic [5:0]           disp_old_prf_0, disp_old_prf_1;
    logic [31:0]          disp_pc_0, disp_pc_1;
    logic [IDXW-1:0]      disp_idx_0, disp_idx_1;
    logic                 rob_ready, rob_empty;
    logic [3:0]           cpl_valid;
    logic [4*IDXW-1:0]    cpl_idx;
    logic                 commit_valid_0, commit_valid_1;
    logic                 commit_wen_0, commit_wen_1;
    logic [4:0]           commit_arch_0, commit_arch_1;
    logic [5:0]           commit_prf_0, commit_prf_1;
    logic [5:0]           commit_old_prf_0, commit_old_prf_1;
    logic [31:0]          commit_pc_0, commit_pc_1;

    modport master (
        output flush,
        output disp_valid_0, disp_valid_1, disp_wen_0, disp_wen_1,
        output disp_arch_0, disp_arch_1, disp_prf_0, disp_prf_1,
        output disp_old_prf_0, disp_old_prf_1, disp_pc_0, disp_pc_1,
        output cpl_valid, cpl_idx,
        input  disp_idx_0, disp_idx_1, rob_ready, rob_empty,
        input  commit_valid_0, commit_valid_1, commit_wen_0, commit_wen_1,
        input  commit_arch_0, commit_arch_1, commit_prf_0, commit_prf_1,
        input  commit_old_prf_0, commit_old_prf_1, commit_pc_0, commit_pc_1
    );

    modport slave (
        input  flush,
        input  disp_valid_0, disp_valid_1, disp_wen_0, disp_wen_1,
        input  disp_arch_0, disp_arch_1, disp_prf_0, disp_prf_1,
        input  disp_old_prf_0, disp_old_prf_1, disp_pc_0, disp_pc_1,
        input  cpl_valid, cpl_idx,
        output disp_idx_0, disp_idx_1, rob_ready, rob_empty,
        output commit_valid_0, commit_valid_1, commit_wen_0, commit_wen_1,
        output commit_arch_0, commit_arch_1, commit_prf_0, commit_prf_1,
        output commit_old_prf_0, commit_old_prf_1, commit_pc_0, commit_pc_1
    );
endinterface

// File: rtl/rob_commit_unit.sv
// Reorder buffer: 2-wide in-order enqueue, 4-port completion, in-order retirement.
// Define ROB_DUAL_COMMIT_EN for 2 retirements/cycle; otherwise slot 1 never commits.
module rob_commit_unit #(
    parameter int DEPTH = 32,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    rob_commit_unit_if.slave rob
);
    typedef logic [IDXW-1:0] idx_t;
    localparam logic [IDXW:0] READY_MAX = (IDXW+1)'(DEPTH - 2);

    logic        valid_q   [DEPTH];
    logic        done_q    [DEPTH];
    logic        wen_q     [DEPTH];
    logic [4:0]  arch_q    [DEPTH];
    logic [5:0]  prf_q     [DEPTH];
    logic [5:0]  old_prf_q [DEPTH];
    logic [31:0] pc_q      [DEPTH];

    idx_t          head_q, head_d, tail_q, tail_d, tail_p1;
    logic [IDXW:0] count_q, count_d, n_enq, n_cmt;
    logic          ready, enq0, enq1, cv0, cv1;
`ifdef ROB_DUAL_COMMIT_EN
    idx_t          head_p1;
`endif

    always_comb begin
        tail_p1 = tail_q + 1'b1;
        ready   = (count_q <= READY_MAX);
        enq0    = ready & rob.disp_valid_0 & ~rob.flush;
        enq1    = enq0 & rob.disp_valid_1;
        cv0     = ~rob.flush & valid_q[head_q] & done_q[head_q];
`ifdef ROB_DUAL_COMMIT_EN
        head_p1 = head_q + 1'b1;
        cv1     = cv0 & valid_q[head_p1] & done_q[head_p1];
`else
        cv1     = 1'b0;
`endif
        n_enq   = {{IDXW{1'b0}}, enq0} + {{IDXW{1'b0}}, enq1};
        n_cmt   = {{IDXW{1'b0}}, cv0} + {{IDXW{1'b0}}, cv1};
        head_d  = head_q + idx_t'(n_cmt);
        tail_d  = tail_q + idx_t'(n_enq);
        count_d = count_q + n_enq - n_cmt;
        if (rob.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    assign rob.rob_ready        = ready;
    assign rob.rob_empty        = (count_q == '0);
    assign rob.disp_idx_0       = tail_q;
    assign rob.disp_idx_1       = tail_p1;
    assign rob.commit_valid_0   = cv0;
    assign rob.commit_wen_0     = wen_q[head_q];
    assign rob.commit_arch_0    = arch_q[head_q];
    assign rob.commit_prf_0     = prf_q[head_q];
    assign rob.commit_old_prf_0 = old_prf_q[head_q];
    assign rob.commit_pc_0      = pc_q[head_q];
    assign rob.commit_valid_1   = cv1;
`ifdef ROB_DUAL_COMMIT_EN
    assign rob.commit_wen_1     = wen_q[head_p1];
    assign rob.commit_arch_1    = arch_q[head_p1];
    assign rob.commit_prf_1     = prf_q[head_p1];
    assign rob.commit_old_prf_1 = old_prf_q[head_p1];
    assign rob.commit_pc_1      = pc_q[head_p1];
`else
    assign rob.commit_wen_1     = 1'b0;
    assign rob.commit_arch_1    = '0;
    assign rob.commit_prf_1     = '0;
    assign rob.commit_old_prf_1 = '0;
    assign rob.commit_pc_1      = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]   <= 1'b0;
                done_q[i]    <= 1'b0;
                wen_q[i]     <= 1'b0;
                arch_q[i]    <= '0;
                prf_q[i]     <= '0;
                old_prf_q[i] <= '0;
                pc_q[i]      <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (rob.flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    valid_q[i] <= 1'b0;
                    done_q[i]  <= 1'b0;
                end
            end else begin
                // Enqueue slots are always invalid here, so same-cycle completion to them is dropped.
                for (int k = 0; k < 4; k++) begin
                    if (rob.cpl_valid[k] && valid_q[rob.cpl_idx[k*IDXW +: IDXW]])
                        done_q[rob.cpl_idx[k*IDXW +: IDXW]] <= 1'b1;
                end
                if (cv0) begin
                    valid_q[head_q] <= 1'b0;
                    done_q[head_q]  <= 1'b0;
                end
`ifdef ROB_DUAL_COMMIT_EN
                if (cv1) begin
                    valid_q[head_p1] <= 1'b0;
                    done_q[head_p1]  <= 1'b0;
                end
`endif
                if (enq0) begin
                    valid_q[tail_q]   <= 1'b1;
                    done_q[tail_q]    <= 1'b0;
                    wen_q[tail_q]     <= rob.disp_wen_0;
                    arch_q[tail_q]    <= rob.disp_arch_0;
                    prf_q[tail_q]     <= rob.disp_prf_0;
                    old_prf_q[tail_q] <= rob.disp_old_prf_0;
                    pc_q[tail_q]      <= rob.disp_pc_0;
                end
                if (enq1) begin
                    valid_q[tail_p1]   <= 1'b1;
                    done_q[tail_p1]    <= 1'b0;
                    wen_q[tail_p1]     <= rob.disp_wen_1;
                    arch_q[tail_p1]    <= rob.disp_arch_1;
                    prf_q[tail_p1]     <= rob.disp_prf_1;
                    old_prf_q[tail_p1] <= rob.disp_old_prf_1;
                    pc_q[tail_p1]      <= rob.disp_pc_1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed scenarios plus random traffic against a queue model.
module tb_rob_commit_unit;
    localparam int DEPTH = 32;
    localparam int IDXW  = 5;
`ifdef ROB_DUAL_COMMIT_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_commit_unit_if #(.IDXW(IDXW)) bus ();
    rob_commit_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .rob(bus));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          idx;
        bit          wen;
        logic [4:0]  arch;
        logic [5:0]  prf;
        logic [5:0]  old;
        logic [31:0] pc;
        bit          done;
    } ent_t;

    // Program-order list of in-flight uOPs; front is the oldest.
    ent_t m_q[$];
    int   m_tail = 0;

    function automatic bit m_cv0();
        return !bus.flush && m_q.size() > 0 && m_q[0].done;
    endfunction

    function automatic bit m_cv1();
        return DUAL && m_cv0() && m_q.size() > 1 && m_q[1].done;
    endfunction

    task automatic drive_idle();
        bus.flush = 0;
        bus.disp_valid_0 = 0; bus.disp_valid_1 = 0;
        bus.disp_wen_0 = 0; bus.disp_wen_1 = 0;
        bus.disp_arch_0 = 0; bus.disp_arch_1 = 0;
        bus.disp_prf_0 = 0; bus.disp_prf_1 = 0;
        bus.disp_old_prf_0 = 0; bus.disp_old_prf_1 = 0;
        bus.disp_pc_0 = 0; bus.disp_pc_1 = 0;
        bus.cpl_valid = 0; bus.cpl_idx = 0;
    endtask

    task automatic set_slot(input int s, input bit wen, input logic [4:0] arch,
                            input logic [5:0] prf, input logic [5:0] old, input logic [31:0] pc);
        if (s == 0) begin
            bus.disp_valid_0 = 1; bus.disp_wen_0 = wen; bus.disp_arch_0 = arch;
            bus.disp_prf_0 = prf; bus.disp_old_prf_0 = old; bus.disp_pc_0 = pc;
        end else begin
            bus.disp_valid_1 = 1; bus.disp_wen_1 = wen; bus.disp_arch_1 = arch;
            bus.disp_prf_1 = prf; bus.disp_old_prf_1 = old; bus.disp_pc_1 = pc;
        end
    endtask

    task automatic set_cpl(input int k, input int idx);
        logic [IDXW-1:0] v;
        v = idx[IDXW-1:0];
        bus.cpl_valid[k] = 1'b1;
        bus.cpl_idx[k*IDXW +: IDXW] = v;
    endtask

    task automatic model_apply();
        int sz0;
        bit c0, c1, rdy;
        int id;
        ent_t e;
        sz0 = m_q.size();
        c0  = m_cv0();
        c1  = m_cv1();
        rdy = (sz0 <= DEPTH - 2);
        if (bus.flush) begin
            m_q.delete();
            m_tail = 0;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            if (bus.cpl_valid[k]) begin
                id = int'(bus.cpl_idx[k*IDXW +: IDXW]);
                foreach (m_q[i]) if (m_q[i].idx == id) m_q[i].done = 1;
            end
        end
        if (c0) void'(m_q.pop_front());
        if (c1) void'(m_q.pop_front());
        if (rdy && bus.disp_valid_0) begin
            e.idx = m_tail; e.wen = bus.disp_wen_0; e.arch = bus.disp_arch_0;
            e.prf = bus.disp_prf_0; e.old = bus.disp_old_prf_0; e.pc = bus.disp_pc_0; e.done = 0;
            m_q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
            if (bus.disp_valid_1) begin
                e.idx = m_tail; e.wen = bus.disp_wen_1; e.arch = bus.disp_arch_1;
                e.prf = bus.disp_prf_1; e.old = bus.disp_old_prf_1; e.pc = bus.disp_pc_1;
                m_q.push_back(e);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    endtask

    task automatic tick();
        model_apply();
        @(posedge clk);
        #2;
        drive_idle();
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (m_q.size() > 0 && guard < 100) begin
            tick();
            guard++;
        end
        #1;
        n_checks++;
        if (bus.rob_empty !== 1'b1 || guard >= 100) begin
            n_fail++;
            $display("FAIL %s_drain: rob_empty=%b guard=%0d, required rob_empty=1 within 100", name, bus.rob_empty, guard);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        #3;
        n_checks++; if (bus.rob_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.rob_empty); end
        n_checks++; if (bus.rob_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.rob_ready); end
        n_checks++; if (bus.commit_valid_0 !== 1'b0 || bus.commit_valid_1 !== 1'b0) begin n_fail++; $display("FAIL reset_cv: got %b%b want 00", bus.commit_valid_1, bus.commit_valid_0); end
        n_checks++; if (bus.disp_idx_0 !== 5'd0 || bus.disp_idx_1 !== 5'd1) begin n_fail++; $display("FAIL reset_idx: got %0d/%0d want 0/1", bus.disp_idx_0, bus.disp_idx_1); end
        m_q.delete();
        m_tail = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_pair_commit();
        set_slot(0, 1, 5'd3, 6'd33, 6'd1, 32'h0);
        set_slot(1, 1, 5'd4, 6'd34, 6'd2, 32'h4);
        #1;
        n_checks++; if (bus.disp_idx_0 !== 5'd0 || bus.disp_idx_1 !== 5'd1) begin n_fail++; $display("FAIL pair_idx: got %0d/%0d want 0/1", bus.disp_idx_0, bus.disp_idx_1); end
        tick();
        set_cpl(0, 1);
        #1;
        n_checks++; if (bus.commit_valid_0 !== 1'b0) begin n_fail++; $display("FAIL pair_wait0: got %b want 0", bus.commit_valid_0); end
        tick();
        set_cpl(2, 0);
        #1;
        n_checks++; if (bus.commit_valid_0 !== 1'b0) begin n_fail++; $display("FAIL pair_wait1: got %b want 0", bus.commit_valid_0); end
        tick();
        #1;
        n_checks++; if (bus.commit_valid_0 !== 1'b1 || bus.commit_pc_0 !== 32'h0 || bus.commit_old_prf_0 !== 6'd1 || bus.commit_prf_0 !== 6'd33)
            begin n_fail++; $display("FAIL pair_slot0: cv=%b pc=%h old=%0d prf=%0d want 1/0/1/33", bus.commit_valid_0, bus.commit_pc_0, bus.commit_old_prf_0, bus.commit_prf_0); end
        n_checks++; if (bus.commit_valid_1 !== DUAL || bus.commit_pc_1 !== (DUAL ? 32'h4 : 32'h0) || bus.commit_old_prf_1 !== (DUAL ? 6'd2 : 6'd0))
            begin n_fail++; $display("FAIL pair_slot1: cv=%b pc=%h old=%0d want %b", bus.commit_valid_1, bus.commit_pc_1, bus.commit_old_prf_1, DUAL); end
        tick();
        #1;
        n_checks++; if (bus.commit_valid_0 !== !DUAL || bus.rob_empty !== DUAL)
            begin n_fail++; $display("FAIL pair_after: cv0=%b empty=%b want %b/%b", bus.commit_valid_0, bus.rob_empty, !DUAL, DUAL); end
        drain("pair");
    endtask

    task automatic test_fill();
        int start;
        start = m_tail;
        for (int i = 0; i < 15; i++) begin
            set_slot(0, 1, 5'(i), 6'(i), 6'(i + 1), 32'(i * 8));
            set_slot(1, 0, 5'(i), 6'(i), 6'(i + 2), 32'(i * 8 + 4));
            tick();
        end
        #1;
        n_checks++; if (bus.rob_ready !== 1'b1 || bus.disp_idx_0 !== 5'((start + 30) % DEPTH))
            begin n_fail++; $display("FAIL fill_30: ready=%b idx=%0d want 1/%0d", bus.rob_ready, bus.disp_idx_0, (start + 30) % DEPTH); end
        set_slot(0, 1, 5'd1, 6'd1, 6'd1, 32'h200);
        tick();
        #1;
        n_checks++; if (bus.rob_ready !== 1'b0 || bus.rob_empty !== 1'b0)
            begin n_fail++; $display("FAIL fill_31: ready=%b empty=%b want 0/0", bus.rob_ready, bus.rob_empty); end
        set_slot(0, 1, 5'd2, 6'd2, 6'd2, 32'h300);
        set_slot(1, 1, 5'd2, 6'd2, 6'd2, 32'h304);
        tick();
        #1;
        n_checks++; if (bus.disp_idx_0 !== 5'((start + 31) % DEPTH) || bus.rob_ready !== 1'b0)
            begin n_fail++; $display("FAIL fill_drop: idx=%0d ready=%b want %0d/0", bus.disp_idx_0, bus.rob_ready, (start + 31) % DEPTH); end
        bus.flush = 1;
        tick();
        #1;
        n_checks++; if (bus.rob_empty !== 1'b1 || bus.disp_idx_0 !== 5'd0)
            begin n_fail++; $display("FAIL fill_flush: empty=%b idx=%0d want 1/0", bus.rob_empty, bus.disp_idx_0); end
    endtask

    task automatic test_wrap();
        int t;
        for (int i = 0; i < 15; i++) begin
            t = m_tail;
            set_slot(0, 1, 5'd7, 6'd9, 6'd10, 32'h500 + 32'(i * 8));
            set_slot(1, 1, 5'd8, 6'd11, 6'd12, 32'h504 + 32'(i * 8));
            if (i > 0) begin set_cpl(0, (t + DEPTH - 2) % DEPTH); set_cpl(1, (t + DEPTH - 1) % DEPTH); end
            tick();
        end
        set_cpl(0, (m_tail + DEPTH - 2) % DEPTH);
        set_cpl(1, (m_tail + DEPTH - 1) % DEPTH);
        tick();
        drain("wrap_prep");
        n_checks++; if (bus.disp_idx_0 !== 5'd30) begin n_fail++; $display("FAIL wrap_tail: got %0d want 30", bus.disp_idx_0); end
        set_slot(0, 1, 5'd1, 6'd40, 6'd20, 32'h100);
        set_slot(1, 1, 5'd2, 6'd41, 6'd21, 32'h104);
        #1;
        n_checks++; if (bus.disp_idx_0 !== 5'd30 || bus.disp_idx_1 !== 5'd31) begin n_fail++; $display("FAIL wrap_idx_a: got %0d/%0d want 30/31", bus.disp_idx_0, bus.disp_idx_1); end
        tick();
        set_slot(0, 1, 5'd3, 6'd42, 6'd22, 32'h108);
        set_slot(1, 1, 5'd4, 6'd43, 6'd23, 32'h10c);
        #1;
        n_checks++; if (bus.disp_idx_0 !== 5'd0 || bus.disp_idx_1 !== 5'd1) begin n_fail++; $display("FAIL wrap_idx_b: got %0d/%0d want 0/1", bus.disp_idx_0, bus.disp_idx_1); end
        tick();
        set_cpl(0, 30); set_cpl(1, 31); set_cpl(2, 0); set_cpl(3, 1);
        tick();
        #1;
        n_checks++; if (bus.commit_valid_0 !== 1'b1 || bus.commit_pc_0 !== 32'h100 || bus.commit_valid_1 !== DUAL || bus.commit_pc_1 !== (DUAL ? 32'h104 : 32'h0))
            begin n_fail++; $display("FAIL wrap_c1: cv=%b%b pc0=%h pc1=%h", bus.commit_valid_1, bus.commit_valid_0, bus.commit_pc_0, bus.commit_pc_1); end
        tick();
        #1;
        n_checks++; if (bus.commit_valid_0 !== 1'b1 || bus.commit_pc_0 !== (DUAL ? 32'h108 : 32'h104) || bus.commit_old_prf_0 !== (DUAL ? 6'd22 : 6'd21))
            begin n_fail++; $display("FAIL wrap_c2: cv0=%b pc0=%h old=%0d", bus.commit_valid_0, bus.commit_pc_0, bus.commit_old_prf_0); end
        drain("wrap");
    endtask

    task automatic test_flush();
        int first;
        first = m_tail;
        set_slot(0, 1, 5'd1, 6'd1, 6'd1, 32'h10); set_slot(1, 1, 5'd2, 6'd2, 6'd2, 32'h14); tick();
        set_slot(0, 1, 5'd3, 6'd3, 6'd3, 32'h18); set_slot(1, 1, 5'd4, 6'd4, 6'd4, 32'h1c); tick();
        set_slot(0, 1, 5'd5, 6'd5, 6'd5, 32'h20); tick();
        set_cpl(0, first);
        tick();
        for (int k = 0; k < 4; k++) set_cpl(k, (first + 1 + k) % DEPTH);
        bus.flush = 1;
        set_slot(0, 1, 5'd6, 6'd6, 6'd6, 32'h24);
        #1;
        n_checks++; if (bus.commit_valid_0 !== 1'b0 || bus.commit_valid_1 !== 1'b0)
            begin n_fail++; $display("FAIL flush_cv: got %b%b want 00", bus.commit_valid_1, bus.commit_valid_0); end
        tick();
        #1;
        n_checks++; if (bus.rob_empty !== 1'b1 || bus.disp_idx_0 !== 5'd0 || bus.commit_valid_0 !== 1'b0)
            begin n_fail++; $display("FAIL flush_after: empty=%b idx=%0d cv0=%b want 1/0/0", bus.rob_empty, bus.disp_idx_0, bus.commit_valid_0); end
        tick();
        #1;
        n_checks++; if (bus.rob_empty !== 1'b1 || bus.commit_valid_0 !== 1'b0)
            begin n_fail++; $display("FAIL flush_hold: empty=%b cv0=%b want 1/0", bus.rob_empty, bus.commit_valid_0); end
    endtask

    task automatic test_back_to_back();
        set_slot(0, 1, 5'd9, 6'd50, 6'd30, 32'h700);
        set_slot(1, 1, 5'd10, 6'd51, 6'd31, 32'h704);
        tick();
        set_cpl(1, 0); set_cpl(3, 1);
        tick();
        #1;
        n_checks++; if (bus.commit_valid_0 !== 1'b1 || bus.commit_valid_1 !== DUAL || bus.commit_arch_0 !== 5'd9)
            begin n_fail++; $display("FAIL b2b_c1: cv=%b%b arch0=%0d want %b1/9", bus.commit_valid_1, bus.commit_valid_0, bus.commit_arch_0, DUAL); end
        tick();
        #1;
        n_checks++; if (bus.commit_valid_0 !== !DUAL || bus.commit_valid_1 !== 1'b0 || bus.rob_empty !== DUAL)
            begin n_fail++; $display("FAIL b2b_c2: cv=%b%b empty=%b", bus.commit_valid_1, bus.commit_valid_0, bus.rob_empty); end
        drain("b2b");
    endtask

    task automatic test_random();
        bit e0, e1;
        for (int c = 0; c < 600; c++) begin
            bus.flush = ($urandom_range(63) == 0);
            if ($urandom_range(9) < 7) begin
                set_slot(0, 1'($urandom), 5'($urandom), 6'($urandom), 6'($urandom), $urandom);
                if ($urandom_range(1) == 1) set_slot(1, 1'($urandom), 5'($urandom), 6'($urandom), 6'($urandom), $urandom);
            end else if ($urandom_range(3) == 0) begin
                set_slot(1, 1, 5'($urandom), 6'($urandom), 6'($urandom), $urandom);
            end
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(1) == 1 && m_q.size() > 0) set_cpl(k, m_q[$urandom_range(m_q.size() - 1)].idx);
                else if ($urandom_range(7) == 0) set_cpl(k, $urandom_range(DEPTH - 1));
            end
            #1;
            e0 = m_cv0();
            e1 = m_cv1();
            n_checks++;
            if (bus.rob_empty !== (m_q.size() == 0) || bus.rob_ready !== (m_q.size() <= DEPTH - 2)
                || bus.disp_idx_0 !== 5'(m_tail) || bus.disp_idx_1 !== 5'((m_tail + 1) % DEPTH)) begin
                n_fail++;
                $display("FAIL rand_status c=%0d: empty=%b ready=%b idx=%0d/%0d, model size=%0d tail=%0d", c,
                         bus.rob_empty, bus.rob_ready, bus.disp_idx_0, bus.disp_idx_1, m_q.size(), m_tail);
            end
            n_checks++;
            if (bus.commit_valid_0 !== e0 || bus.commit_valid_1 !== e1) begin
                n_fail++;
                $display("FAIL rand_cv c=%0d: got %b%b want %b%b", c, bus.commit_valid_1, bus.commit_valid_0, e1, e0);
            end
            if (e0) begin
                n_checks++;
                if (bus.commit_pc_0 !== m_q[0].pc || bus.commit_old_prf_0 !== m_q[0].old || bus.commit_prf_0 !== m_q[0].prf
                    || bus.commit_arch_0 !== m_q[0].arch || bus.commit_wen_0 !== m_q[0].wen) begin
                    n_fail++;
                    $display("FAIL rand_slot0 c=%0d: pc=%h old=%0d want pc=%h old=%0d", c, bus.commit_pc_0, bus.commit_old_prf_0, m_q[0].pc, m_q[0].old);
                end
            end
            if (e1) begin
                n_checks++;
                if (bus.commit_pc_1 !== m_q[1].pc || bus.commit_old_prf_1 !== m_q[1].old || bus.commit_prf_1 !== m_q[1].prf
                    || bus.commit_arch_1 !== m_q[1].arch || bus.commit_wen_1 !== m_q[1].wen) begin
                    n_fail++;
                    $display("FAIL rand_slot1 c=%0d: pc=%h old=%0d want pc=%h old=%0d", c, bus.commit_pc_1, bus.commit_old_prf_1, m_q[1].pc, m_q[1].old);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midop();
        set_slot(0, 1, 5'd1, 6'd1, 6'd1, 32'h40);
        set_slot(1, 1, 5'd1, 6'd1, 6'd1, 32'h44);
        tick();
        #1;
        rst_n = 0;
        #1;
        n_checks++; if (bus.rob_empty !== 1'b1 || bus.disp_idx_0 !== 5'd0 || bus.commit_valid_0 !== 1'b0)
            begin n_fail++; $display("FAIL reset_midop: empty=%b idx=%0d cv0=%b want 1/0/0", bus.rob_empty, bus.disp_idx_0, bus.commit_valid_0); end
        m_q.delete();
        m_tail = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_pair_commit();
        test_fill();
        test_wrap();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
